// File: rtl/apb_evt_slave.sv
// APB completer for the event-to-APB master: three event data registers, saturating hit
// counters, programmable wait states and pslverr signalling for decode/protocol errors.
module apb_evt_slave #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             psel_i,
  input  logic             penable_i,
  input  logic [31:0]      paddr_i,
  input  logic             pwrite_i,
  input  logic [31:0]      pwdata_i,
  output logic [31:0]      prdata_o,
  output logic             pready_o,
  output logic             pslverr_o,
  output logic [31:0]      data_a_o,
  output logic [31:0]      data_b_o,
  output logic [31:0]      data_c_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic [CNT_W-1:0] cnt_c_o,
  output logic [7:0]       err_cnt_o
);

  localparam logic [31:0] AddrDataA = 32'h1000_1000;
  localparam logic [31:0] AddrCntA  = 32'h1000_1004;
  localparam logic [31:0] AddrDataB = 32'h2000_2000;
  localparam logic [31:0] AddrCntB  = 32'h2000_2004;
  localparam logic [31:0] AddrDataC = 32'h3000_3000;
  localparam logic [31:0] AddrCntC  = 32'h3000_3004;

  typedef enum logic {StIdle, StAccess} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             wcnt_q, wcnt_d;
  logic [2:0][31:0]       data_q;
  logic [2:0][CNT_W-1:0]  cnt_q;
  logic [7:0]             err_q;

  logic [2:0]  hit_data, hit_cnt;
  logic        dec_err;
  logic [31:0] rd_mux;
  logic        wr_en, err_inc;

  assign hit_data = {paddr_i == AddrDataC, paddr_i == AddrDataB, paddr_i == AddrDataA};
  assign hit_cnt  = {paddr_i == AddrCntC, paddr_i == AddrCntB, paddr_i == AddrCntA};
  assign dec_err  = !(|hit_data || |hit_cnt) || (pwrite_i && |hit_cnt);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < 3; i++) begin
      if (hit_data[i]) rd_mux = data_q[i];
      if (hit_cnt[i])  rd_mux = 32'(cnt_q[i]);
    end
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    pready_o  = 1'b1;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    wr_en     = 1'b0;
    err_inc   = 1'b0;
    // Outputs are forced to their idle values while reset is held.
    if (rst) begin
      unique case (state_q)
        StIdle: begin
          if (psel_i && !penable_i) begin
            state_d = StAccess;
            wcnt_d  = 4'(WAIT_CYCLES);
          end else if (psel_i && penable_i) begin
            pslverr_o = 1'b1;
            err_inc   = 1'b1;
          end
        end
        StAccess: begin
          pready_o = (wcnt_q == 4'd0);
          if (wcnt_q != 4'd0) wcnt_d = wcnt_q - 4'd1;
          if (!psel_i) begin
            state_d = StIdle;
            wcnt_d  = '0;
          end else if (penable_i && wcnt_q == 4'd0) begin
            state_d = StIdle;
            if (dec_err) begin
              pslverr_o = 1'b1;
              err_inc   = 1'b1;
            end else begin
              wr_en    = pwrite_i;
              prdata_o = pwrite_i ? 32'd0 : rd_mux;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wr_en && hit_data[i]) begin
          data_q[i] <= pwdata_i;
          if (cnt_q[i] != {CNT_W{1'b1}}) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  assign data_a_o  = data_q[0];
  assign data_b_o  = data_q[1];
  assign data_c_o  = data_q[2];
  assign cnt_a_o   = cnt_q[0];
  assign cnt_b_o   = cnt_q[1];
  assign cnt_c_o   = cnt_q[2];
  assign err_cnt_o = err_q;

endmodule

// File: tb/tb_apb_evt_slave.sv
// Self-checking bench: three apb_evt_slave instances with different wait/counter widths,
// directed scenarios plus random traffic compared against an address-map reference model.
module tb_apb_evt_slave;

  localparam int unsigned WCS[3] = '{2, 0, 1};
  localparam int unsigned CWS[3] = '{16, 16, 2};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel[3], penable[3], pwrite[3];
  logic [31:0] paddr[3], pwdata[3];
  logic [31:0] prdata[3];
  logic        pready[3], pslverr[3];
  logic [31:0] data_o[3][3];
  logic [31:0] cnt_o[3][3];
  logic [7:0]  err_o[3];

  int n_chk = 0;
  int n_err = 0;

  // Reference state: what each register should hold, by event.
  logic [31:0] m_data[3][3];
  int          m_cnt[3][3];
  int          m_err[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CW = CWS[g];
    logic [CW-1:0] ca, cb, cc;
    apb_evt_slave #(.WAIT_CYCLES(WCS[g]), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .psel_i    (psel[g]),
      .penable_i (penable[g]),
      .paddr_i   (paddr[g]),
      .pwrite_i  (pwrite[g]),
      .pwdata_i  (pwdata[g]),
      .prdata_o  (prdata[g]),
      .pready_o  (pready[g]),
      .pslverr_o (pslverr[g]),
      .data_a_o  (data_o[g][0]),
      .data_b_o  (data_o[g][1]),
      .data_c_o  (data_o[g][2]),
      .cnt_a_o   (ca),
      .cnt_b_o   (cb),
      .cnt_c_o   (cc),
      .err_cnt_o (err_o[g])
    );
    assign cnt_o[g][0] = 32'(ca);
    assign cnt_o[g][1] = 32'(cb);
    assign cnt_o[g][2] = 32'(cc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 3; d++) begin
      m_err[d] = 0;
      for (int e = 0; e < 3; e++) begin
        m_data[d][e] = '0;
        m_cnt[d][e]  = 0;
      end
    end
  endfunction

  // Events live at 0xN000_N000 (data) and +4 (count), N = 1..3.
  function automatic void decode(input logic [31:0] a, output int ev, output bit is_cnt,
                                 output bit mapped);
    ev = 0; is_cnt = 0; mapped = 0;
    for (int n = 1; n <= 3; n++) begin
      logic [31:0] base;
      base = (n * 32'h1000_0000) + (n * 32'h1000);
      if (a == base)     begin ev = n - 1; mapped = 1; end
      if (a == base + 4) begin ev = n - 1; mapped = 1; is_cnt = 1; end
    end
  endfunction

  function automatic void model_resp(input int d, input logic wr, input logic [31:0] a,
                                     output bit err, output logic [31:0] rd);
    int ev; bit is_cnt, mapped;
    decode(a, ev, is_cnt, mapped);
    err = !mapped || (wr && is_cnt);
    rd  = err ? 32'd0 : (is_cnt ? 32'(m_cnt[d][ev]) : m_data[d][ev]);
  endfunction

  function automatic void model_commit(input int d, input logic wr, input logic [31:0] a,
                                       input logic [31:0] wd, input bit err);
    int ev; bit is_cnt, mapped;
    longint cmax;
    decode(a, ev, is_cnt, mapped);
    cmax = (longint'(1) << CWS[d]) - 1;
    if (err) begin
      if (m_err[d] < 255) m_err[d]++;
    end else if (wr) begin
      m_data[d][ev] = wd;
      if (m_cnt[d][ev] < cmax) m_cnt[d][ev]++;
    end
  endfunction

  task automatic check_regs(input int d);
    for (int e = 0; e < 3; e++) begin
      check_eq($sformatf("data%0d_%0d", d, e), data_o[d][e], m_data[d][e]);
      check_eq($sformatf("cnt%0d_%0d", d, e), cnt_o[d][e], 32'(m_cnt[d][e]));
    end
    check_eq($sformatf("errcnt%0d", d), 32'(err_o[d]), 32'(m_err[d]));
  endtask

  task automatic release_all();
    for (int k = 0; k < 3; k++) begin
      psel[k]    = 1'b0;
      penable[k] = 1'($urandom);
      paddr[k]   = $urandom;
      pwrite[k]  = 1'($urandom);
      pwdata[k]  = $urandom;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      release_all();
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check_eq("idle_rdy", 32'(pready[k]), 1);
        check_eq("idle_slverr", 32'(pslverr[k]), 0);
        check_eq("idle_rdata", prdata[k], 0);
      end
    end
  endtask

  task automatic setup(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk); #1;
    release_all();
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(negedge clk);
    check_eq("setup_rdy", 32'(pready[d]), 1);
    @(posedge clk); #1;
    penable[d] = 1'b1;
  endtask

  task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    bit err, done;
    logic [31:0] rd;
    int waits;
    model_resp(d, wr, a, err, rd);
    setup(d, wr, a, wd);
    waits = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pready[d]) begin
        done = 1;
        check_eq("slverr", 32'(pslverr[d]), 32'(err));
        if (!wr) check_eq("rdata", prdata[d], rd);
      end else begin
        check_eq("wait_slverr", 32'(pslverr[d]), 0);
        waits++;
        @(posedge clk); #1;
      end
    end
    check_eq("done", 32'(done), 1);
    check_eq("waits", 32'(waits), WCS[d]);
    if (done) model_commit(d, wr, a, wd, err);
  endtask

  task automatic no_setup_access(input int d);
    @(posedge clk); #1;
    release_all();
    psel[d] = 1'b1; penable[d] = 1'b1; paddr[d] = 32'h1000_1000; pwrite[d] = 1'b1;
    @(negedge clk);
    check_eq("nosetup_rdy", 32'(pready[d]), 1);
    check_eq("nosetup_slverr", 32'(pslverr[d]), 1);
    check_eq("nosetup_rdata", prdata[d], 0);
    model_commit(d, 1'b1, 32'h0, 32'h0, 1'b1);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] map[6];
    map = '{32'h1000_1000, 32'h1000_1004, 32'h2000_2000, 32'h2000_2004,
            32'h3000_3000, 32'h3000_3004};
    if ($urandom_range(0, 7) == 0) return $urandom;
    return map[$urandom_range(0, 5)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
        psel[k] = 1'($urandom); penable[k] = 1'($urandom); paddr[k] = rand_addr();
        pwrite[k] = 1'($urandom); pwdata[k] = $urandom;
      end
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_eq("rst_rdy", 32'(pready[d]), 1);
      check_eq("rst_slverr", 32'(pslverr[d]), 0);
      check_eq("rst_rdata", prdata[d], 0);
      check_regs(d);
    end
    release_all();
    rst = 1'b1;
    idle(2);

    // Two wait states on instance 0.
    xfer(0, 1'b1, 32'h1000_1000, 32'hDEAD_CAFE);
    idle(1);
    check_eq("plan_data_a", data_o[0][0], 32'hDEAD_CAFE);
    check_eq("plan_cnt_a", cnt_o[0][0], 1);
    check_regs(0);

    // Zero-wait back-to-back on instance 1.
    xfer(1, 1'b1, 32'h2000_2000, 32'hBD5B_95FC);
    xfer(1, 1'b1, 32'h3000_3000, 32'h9D09_62FA);
    idle(1);
    check_eq("b2b_data_b", data_o[1][1], 32'hBD5B_95FC);
    check_eq("b2b_data_c", data_o[1][2], 32'h9D09_62FA);
    check_eq("b2b_cnt_b", cnt_o[1][1], 1);
    check_eq("b2b_cnt_c", cnt_o[1][2], 1);
    check_regs(1);

    // Error responses.
    xfer(0, 1'b1, 32'h1000_1004, 32'h1234_5678);
    idle(1);
    check_eq("err_cnt_a", cnt_o[0][0], 1);
    check_eq("err_cnt1", 32'(err_o[0]), 1);
    xfer(0, 1'b0, 32'h4000_0000, 32'h0);
    idle(1);
    check_eq("err_cnt2", 32'(err_o[0]), 2);
    check_regs(0);

    // Saturation with a 2-bit counter.
    for (int i = 1; i <= 5; i++) xfer(2, 1'b1, 32'h1000_1000, 32'(i));
    xfer(2, 1'b0, 32'h1000_1004, 32'h0);
    idle(1);
    check_eq("sat_cnt_a", cnt_o[2][0], 3);
    check_eq("sat_data_a", data_o[2][0], 5);
    check_regs(2);

    // Abort by dropping psel during wait states.
    setup(0, 1'b1, 32'h2000_2000, 32'hAAAA_5555);
    @(negedge clk);
    check_eq("abort_wait_rdy", 32'(pready[0]), 0);
    @(posedge clk); #1;
    psel[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_slverr", 32'(pslverr[0]), 0);
    idle(1);
    check_regs(0);
    xfer(0, 1'b0, 32'h2000_2004, 32'h0);
    idle(1);

    // Reset in the middle of an access phase.
    setup(0, 1'b1, 32'h3000_3000, 32'h5555_AAAA);
    @(negedge clk);
    check_eq("mid_wait_rdy", 32'(pready[0]), 0);
    #2;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_rdy", 32'(pready[0]), 1);
    check_eq("mid_rst_slverr", 32'(pslverr[0]), 0);
    model_reset();
    for (int d = 0; d < 3; d++) check_regs(d);
    release_all();
    @(negedge clk);
    rst = 1'b1;
    xfer(0, 1'b1, 32'h3000_3000, 32'h0BAD_F00D);
    idle(1);
    check_eq("post_rst_data_c", data_o[0][2], 32'h0BAD_F00D);
    check_regs(0);

    // Random traffic across all instances.
    for (int it = 0; it < 300; it++) begin
      int d, kind;
      d = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      if (kind == 0) idle($urandom_range(1, 2));
      else if (kind == 1) no_setup_access(d);
      else xfer(d, 1'($urandom), rand_addr(), $urandom);
      if ((it % 25) == 24) begin
        idle(1);
        for (int k = 0; k < 3; k++) check_regs(k);
      end
    end
    idle(1);
    for (int k = 0; k < 3; k++) check_regs(k);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/apb_evt_slave.md
# apb_evt_slave

APB completer that terminates the write transactions produced by the event-to-APB master. It decodes the three per-event addresses and stores the last write data for each event. It keeps saturating per-event hit counters, inserts a programmable number of wait states, and flags protocol and decode errors through pslverr. Its stored data and counters are exposed as sideband outputs and as APB read registers.

## Interface
- WAIT_CYCLES, default 1: wait states inserted in every access phase; legal range 0..15.
- CNT_W, default 16: width of the per-event hit counters.
- clk  in  1  clock, all flops on posedge.
- rst  in  1  reset; one clock, asynchronous, active-low.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- paddr_i  in  32  APB address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  32  write data.
- prdata_o  out  32  read data, valid in the completion cycle.
- pready_o  out  1  transfer complete / wait-state control.
- pslverr_o  out  1  error response, valid in the completion cycle.
- data_a_o, data_b_o, data_c_o  out  32 each  last data written to each event address.
- cnt_a_o, cnt_b_o, cnt_c_o  out  CNT_W each  accepted writes per event, saturating.
- err_cnt_o  out  8  error completions, saturating at 8'hFF.

## Operation
- Address map:
  - 0x1000_1000 data A, RW; 0x1000_1004 cnt A, RO.
  - 0x2000_2000 data B, RW; 0x2000_2004 cnt B, RO.
  - 0x3000_3000 data C, RW; 0x3000_3004 cnt C, RO.
  - Counters are zero-extended to 32 bits on read.
- FSM has two states, IDLE and ACCESS, plus a 4-bit wait counter wcnt.
- IDLE:
  - pready_o = 1.
  - psel_i & !penable_i (setup phase): load wcnt = WAIT_CYCLES, go to ACCESS.
  - psel_i & penable_i (access without setup): completes this cycle with pslverr_o = 1, no register update, err_cnt +1.
- ACCESS:
  - pready_o = (wcnt == 0); while wcnt != 0, decrement by 1 per cycle.
  - Completion = psel_i & penable_i & pready_o. On completion, go to IDLE.
  - psel_i low in ACCESS is an abort: go to IDLE, no update, no error.
- On a completing write to a data address: the data register loads pwdata_i, and the matching counter increments unless it is all-ones.
- Error responses (pslverr_o = 1, prdata_o = 0, no update, err_cnt +1) on completion for:
  - any unmapped address;
  - a write to a counter address.
- Reads of mapped addresses return the register value with pslverr_o = 0.
- prdata_o and pslverr_o are combinational from the decode and are 0 outside the completion cycle.
- paddr_i, pwrite_i and pwdata_i are sampled only in the completion cycle.
- Reset values:
  - state IDLE, wcnt 0;
  - pready_o 1, pslverr_o 0, prdata_o 0;
  - all data, cnt and err_cnt outputs 0.

## Timing
- pready_o is high in IDLE. The upstream master only advances its state when pready is high, so pready_o must never be low outside an access phase.
- Access latency: for a transfer with setup in cycle T, completion occurs in cycle T+1+WAIT_CYCLES. With WAIT_CYCLES = 0 completion is in T+1, zero wait.
- Register outputs (data, cnt, err_cnt) change on the clock edge that ends the completion cycle and are visible from the next cycle.
- Back-to-back: a setup phase in the cycle after completion is accepted with no idle cycle, since ACCESS→IDLE happens on that same edge.
- Reset asserted mid-transfer: the transfer is discarded. No register update; pready_o returns to 1 immediately (asynchronously).
- Counter saturation: a write when cnt = all-ones is still accepted, the data register updates and the count holds.
- penable_i may sit high while psel_i is low (the master resets penable high); psel_i gates all decode.

## Test plan
- Reset: hold rst = 0 for 3 cycles with random APB inputs -> pready_o = 1, pslverr_o = 0, all data/cnt/err outputs 0.
- WAIT_CYCLES = 2; write 0xDEAD_CAFE to 0x1000_1000 -> pready_o low for 2 access cycles, high on the 3rd; then data_a_o = 0xDEAD_CAFE, cnt_a_o = 1, pslverr_o = 0.
- Back-to-back writes to 0x2000_2000 (0xBD5B_95FC) then 0x3000_3000 (0x9D09_62FA), WAIT_CYCLES = 0 -> each completes in 2 cycles; data_b_o and data_c_o hold those values; cnt_b_o = cnt_c_o = 1.
- Error cases:
  - write to 0x1000_1004 -> pslverr_o = 1, cnt_a_o unchanged, err_cnt_o = 1;
  - read of 0x4000_0000 -> prdata_o = 0, pslverr_o = 1, err_cnt_o = 2.
- CNT_W = 2; five writes to 0x1000_1000 with data 1..5 -> cnt_a_o saturates at 3, data_a_o = 5.
- Abort and reset: drop psel_i during wait states -> no update, FSM returns to IDLE. Assert rst during a subsequent access phase -> outputs return to reset values; the next write completes normally.
